// File: rtl/scarv_cop_palu_mpadd_if.sv
`default_nettype none
// ============================================================================
// Module      : scarv_cop_palu_mpadd_if
// Description : Operand/result handshake bundle for the multi-precision
//               packed adder. The sat signal exists only when
//               SCARV_COP_PALU_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface scarv_cop_palu_mpadd_if #(
    parameter int XLEN = 32
);
    localparam int NLANE = XLEN / 2;

    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [2:0]       pw;
    logic             sub;
    logic             ci;
`ifdef SCARV_COP_PALU_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  c;
    logic [NLANE-1:0] co_lanes;
    logic             co;

    modport master (
`ifdef SCARV_COP_PALU_SAT_EN
        output sat,
`endif
        output in_valid, in_first, a, b, pw, sub, ci, out_ready,
        input  in_ready, out_valid, c, co_lanes, co
    );

    modport slave (
`ifdef SCARV_COP_PALU_SAT_EN
        input  sat,
`endif
        input  in_valid, in_first, a, b, pw, sub, ci, out_ready,
        output in_ready, out_valid, c, co_lanes, co
    );
endinterface
`default_nettype wire

// File: rtl/scarv_cop_palu_mpadd.sv
`default_nettype none
// ============================================================================
// Module      : scarv_cop_palu_mpadd
// Description : Registered multi-precision packed add/sub with per-lane carry
//               chaining across beats. Optional unsigned saturation on
//               single-beat ops is enabled by SCARV_COP_PALU_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module scarv_cop_palu_mpadd #(
    parameter int XLEN = 32
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    scarv_cop_palu_mpadd_if.slave bus
);
    localparam int NLANE = XLEN / 2;
    localparam int LIDX  = $clog2(NLANE);

    logic             r_out_valid;
    logic [XLEN-1:0]  r_c;
    logic [NLANE-1:0] r_co_lanes;
    logic             r_co;
    logic [NLANE-1:0] r_carry;
    logic             r_active;
    logic [2:0]       r_pw;
    logic             r_sub;

    logic             w_in_ready;
    logic             w_fire;
    logic             w_first;
    logic             w_sub;
    logic [2:0]       w_pw;
    logic [2:0]       w_lw_log;
    logic [NLANE-1:0] w_cin;
    logic [XLEN-1:0]  w_sum;
    logic [NLANE-1:0] w_cout;
    logic             w_co;
    logic [XLEN-1:0]  w_res;
    logic [NLANE-1:0] w_carry_nxt;
    logic             w_active_nxt;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_fire     = bus.in_valid && w_in_ready;
    assign w_first    = bus.in_first || !r_active;
    assign w_sub      = w_first ? bus.sub : r_sub;
    assign w_pw       = w_first ? bus.pw  : r_pw;

    // Lane width is 2**w_lw_log bits; unused pw encodings fall back to 32b.
    always_comb begin
        case (w_pw)
            3'b001:  w_lw_log = 3'd4;
            3'b010:  w_lw_log = 3'd3;
            3'b011:  w_lw_log = 3'd2;
            3'b100:  w_lw_log = 3'd1;
            default: w_lw_log = 3'd5;
        endcase
    end

    assign w_cin = w_first ? {{(NLANE-1){w_sub}}, bus.ci} : r_carry;

    // Bit-serial ripple that reloads the carry at every lane boundary.
    always_comb begin
        logic            w_carry;
        logic            w_bb;
        logic [LIDX-1:0] w_lane;
        int              w_lw;
        w_sum   = '0;
        w_cout  = '0;
        w_carry = 1'b0;
        w_bb    = 1'b0;
        w_lane  = '0;
        w_lw    = 32'(1) << w_lw_log;
        for (int j = 0; j < XLEN; j++) begin
            w_lane = LIDX'(j >> w_lw_log);
            if ((j & (w_lw - 1)) == 0) begin
                w_carry = w_cin[w_lane];
            end
            w_bb     = bus.b[j] ^ w_sub;
            w_sum[j] = bus.a[j] ^ w_bb ^ w_carry;
            w_carry  = (bus.a[j] & w_bb) | (bus.a[j] & w_carry) | (w_bb & w_carry);
            if ((j & (w_lw - 1)) == (w_lw - 1)) begin
                w_cout[w_lane] = w_carry;
            end
        end
        w_co = w_carry;
    end

`ifdef SCARV_COP_PALU_SAT_EN
    logic w_sat;
    assign w_sat = w_first && bus.sat;

    // Add overflow clamps a lane to all-ones, subtract borrow clamps to zero.
    always_comb begin
        logic [LIDX-1:0] w_slane;
        w_res   = w_sum;
        w_slane = '0;
        for (int j = 0; j < XLEN; j++) begin
            w_slane = LIDX'(j >> w_lw_log);
            if (w_sat) begin
                if (w_sub) begin
                    w_res[j] = w_cout[w_slane] ? w_sum[j] : 1'b0;
                end else begin
                    w_res[j] = w_cout[w_slane] ? 1'b1 : w_sum[j];
                end
            end
        end
    end

    assign w_carry_nxt  = w_sat ? '0 : w_cout;
    assign w_active_nxt = !w_sat;
`else
    assign w_res        = w_sum;
    assign w_carry_nxt  = w_cout;
    assign w_active_nxt = 1'b1;
`endif

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_co_lanes  <= '0;
            r_co        <= 1'b0;
            r_carry     <= '0;
            r_active    <= 1'b0;
            r_pw        <= 3'b000;
            r_sub       <= 1'b0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_c         <= w_res;
            r_co_lanes  <= w_cout;
            r_co        <= w_co;
            r_carry     <= w_carry_nxt;
            r_active    <= w_active_nxt;
            if (w_first) begin
                r_pw  <= bus.pw;
                r_sub <= bus.sub;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.c         = r_c;
    assign bus.co_lanes  = r_co_lanes;
    assign bus.co        = r_co;
endmodule
`default_nettype wire

// File: tb/tb_scarv_cop_palu_mpadd.sv
`default_nettype none
// ============================================================================
// Module      : tb_scarv_cop_palu_mpadd
// Description : Directed vector bench for scarv_cop_palu_mpadd (XLEN=32);
//               covers the saturating path when SCARV_COP_PALU_SAT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scarv_cop_palu_mpadd;
    localparam int XLEN = 32;

    logic g_clk;
    logic g_reset;
    int   n_checks;
    int   n_fail;

    scarv_cop_palu_mpadd_if #(.XLEN(XLEN)) bus ();

    scarv_cop_palu_mpadd #(.XLEN(XLEN)) dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .bus     (bus)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct {
        logic        first;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  pw;
        logic        sub;
        logic        ci;
        logic [31:0] ec;
        logic [15:0] ecl;
        logic        eco;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [63:0] status();
        return {14'd0, bus.out_valid, bus.c, bus.co_lanes, bus.co};
    endfunction

    function automatic logic [63:0] expect_st(input logic ov, input logic [31:0] c,
                                              input logic [15:0] cl, input logic co);
        return {14'd0, ov, c, cl, co};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one beat, wait (bounded) for in_ready, let it fire, sample #1 later.
    task automatic send(input logic first, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] pw, input logic sub, input logic ci);
        int n;
        bus.in_first = first;
        bus.a        = a;
        bus.b        = b;
        bus.pw       = pw;
        bus.sub      = sub;
        bus.ci       = ci;
        bus.in_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge g_clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", n);
        end
        @(posedge g_clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{1'b1, 32'h01FF80FF, 32'h01010101, 3'b010, 1'b0, 1'b0, 32'h02008100, 16'h0005, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b000, 1'b0, 1'b0, 32'h00000000, 16'h0001, 1'b1};
        vecs[2]  = '{1'b0, 32'h00000000, 32'h00000000, 3'b010, 1'b1, 1'b0, 32'h00000001, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 32'h00050003, 32'h00010004, 3'b001, 1'b1, 1'b1, 32'h0004FFFF, 16'h0002, 1'b1};
        vecs[4]  = '{1'b0, 32'h00000000, 32'h00000000, 3'b000, 1'b0, 1'b0, 32'h0000FFFF, 16'h0002, 1'b1};
        vecs[5]  = '{1'b1, 32'h12345678, 32'h11111111, 3'b011, 1'b0, 1'b1, 32'h2345678A, 16'h0000, 1'b0};
        vecs[6]  = '{1'b1, 32'hFFFFFFFF, 32'h55555555, 3'b100, 1'b0, 1'b0, 32'h00000000, 16'hFFFF, 1'b1};
        vecs[7]  = '{1'b1, 32'h80000000, 32'h80000000, 3'b111, 1'b0, 1'b1, 32'h00000001, 16'h0001, 1'b1};
        vecs[8]  = '{1'b1, 32'h10203040, 32'h20103040, 3'b010, 1'b1, 1'b1, 32'hF0100000, 16'h0007, 1'b0};
        vecs[9]  = '{1'b0, 32'h00000000, 32'h00000000, 3'b010, 1'b1, 1'b1, 32'hFF000000, 16'h0007, 1'b0};
        vecs[10] = '{1'b1, 32'h00000005, 32'h00000003, 3'b000, 1'b1, 1'b0, 32'h00000001, 16'h0001, 1'b1};

        g_reset       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.pw        = 3'b000;
        bus.sub       = 1'b0;
        bus.ci        = 1'b0;
        bus.out_ready = 1'b1;
`ifdef SCARV_COP_PALU_SAT_EN
        bus.sat       = 1'b0;
`endif
        repeat (2) @(posedge g_clk);
        #1;
        g_reset = 1'b0;
        check("reset_state", status(), expect_st(1'b0, 32'h0, 16'h0, 1'b0));
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

        for (int i = 0; i < 11; i++) begin
            send(vecs[i].first, vecs[i].a, vecs[i].b, vecs[i].pw, vecs[i].sub, vecs[i].ci);
            check($sformatf("vec%0d", i), status(),
                  expect_st(1'b1, vecs[i].ec, vecs[i].ecl, vecs[i].eco));
        end

        // Backpressure: result held, second beat fires on the accepting edge.
        @(posedge g_clk);
        #1;
        bus.out_ready = 1'b0;
        send(1'b1, 32'd1, 32'd2, 3'b000, 1'b0, 1'b0);
        check("bp_first", status(), expect_st(1'b1, 32'd3, 16'h0, 1'b0));
        check("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
        bus.in_first = 1'b1;
        bus.a        = 32'd10;
        bus.b        = 32'd20;
        bus.in_valid = 1'b1;
        repeat (2) @(posedge g_clk);
        #1;
        check("bp_hold", status(), expect_st(1'b1, 32'd3, 16'h0, 1'b0));
        @(negedge g_clk);
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", {63'd0, bus.in_ready}, 64'd1);
        @(posedge g_clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_second", status(), expect_st(1'b1, 32'd30, 16'h0, 1'b0));
        @(posedge g_clk);
        #1;
        check("bp_drain", {63'd0, bus.out_valid}, 64'd0);

        // Reset mid-operation drops the chained carry and the active flag.
        send(1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b000, 1'b0, 1'b0);
        check("rst_beat1", status(), expect_st(1'b1, 32'h0, 16'h0001, 1'b1));
        g_reset = 1'b1;
        @(posedge g_clk);
        #1;
        g_reset = 1'b0;
        check("rst_mid_op", status(), expect_st(1'b0, 32'h0, 16'h0, 1'b0));
        send(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        check("rst_then_cont", status(), expect_st(1'b1, 32'h0, 16'h0, 1'b0));

`ifdef SCARV_COP_PALU_SAT_EN
        bus.sat = 1'b1;
        send(1'b1, 32'hF0F0F0F0, 32'h20202020, 3'b010, 1'b0, 1'b0);
        check("sat_add", status(), expect_st(1'b1, 32'hFFFFFFFF, 16'h000F, 1'b1));
        bus.sat = 1'b0;
        send(1'b0, 32'h0, 32'h0, 3'b010, 1'b0, 1'b0);
        check("sat_then_cont", status(), expect_st(1'b1, 32'h0, 16'h0, 1'b0));
        bus.sat = 1'b1;
        send(1'b1, 32'h10FF0510, 32'h20010610, 3'b010, 1'b1, 1'b1);
        check("sat_sub", status(), expect_st(1'b1, 32'h00FE0000, 16'h0005, 1'b0));
        bus.sat = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/scarv_cop_palu_mpadd.md
Name: scarv_cop_palu_mpadd

Overview:
- Registered, multi-precision packed adder/subtractor for the SCARV coprocessor PALU; successor to the combinational packed adder.
- Generalised to XLEN-bit operands and 32/16/8/4/2-bit lanes, with a valid/ready handshake.
- Keeps a per-lane carry register, so consecutive beats chain carries lane-wise. This allows multi-word (multi-precision) packed arithmetic.
- Sits between the coprocessor register-read stage and writeback.

Parameters:
- XLEN, 32, operand width; must be a multiple of 32.
- NLANE, XLEN/2, derived (localparam): maximum lane count, i.e. the width of the co_lanes vector.

Ports:
- g_clk  in  1  clock
- g_reset  in  1  synchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_first  in  1  beat starts a new operation (uses fresh carry-ins)
- a  in  XLEN  LHS
- b  in  XLEN  RHS
- pw  in  3  pack width: 000=32b, 001=16b, 010=8b, 011=4b, 100=2b lanes; others treated as 000
- sub  in  1  subtract (b inverted per lane)
- ci  in  1  carry-in to lane 0 on a first beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- c  out  XLEN  packed result
- co_lanes  out  NLANE  per-lane carry-out; bit i = lane i; bits at or above the active lane count are 0
- co  out  1  carry-out of the most significant lane

Behaviour:
- Reset (synchronous, g_reset=1 at the clock edge):
  - out_valid=0, c=0, co_lanes=0, co=0.
  - Carry register=0, active=0, latched pw/sub=0.
  - in_ready is combinational and equals 1 after reset.
  - Reset mid-operation discards the operation and any pending result.
- Fire = in_valid && in_ready.
  - in_ready = !out_valid || out_ready (one-deep output register, no skid).
- Latency: 1 cycle. A result fired at edge N is visible from edge N with out_valid=1.
  - It is held stable until out_valid && out_ready.
  - With no new fire, out_valid clears on that accepting edge.
- First beat: in_first=1, OR active=0 (a beat with in_first=0 when idle is treated as first).
  - pw and sub are latched and active is set.
  - Lane 0 carry-in = ci; every other lane carry-in = sub.
  - This matches the single-word adder, where subtract requires ci=1.
- Continuation beat: in_first=0 and active=1.
  - Latched pw/sub are used; pw and sub inputs are ignored.
  - Lane i carry-in = stored carry-out of lane i from the previous beat.
- Per lane, width W = XLEN/lane count:
  - {cout, r} = a_lane + (sub ? ~b_lane : b_lane) + cin, computed modulo 2^W.
  - Carries never cross lane boundaries.
- On every fire, the carry register is loaded with the lane carry-outs.
  - co_lanes reflects the same values; co = carry-out of the top lane.
- in_first=1 while active=1 restarts the operation; the stored carries are not used.
- Simultaneous output accept and new fire on the same edge: the new result is loaded and out_valid stays 1.

Optional Feature:
- Macro: SCARV_COP_PALU_SAT_EN.
- When defined:
  - Adds input port sat (1 bit).
  - On a first beat with sat=1, each lane saturates unsigned: add overflow (cout=1) gives all-ones; sub borrow (cout=0) gives zero.
  - co_lanes still reports the raw carries.
  - The carry register is cleared and active=0, so saturating ops are single-beat only.
  - sat on a continuation beat is ignored.
- When undefined: no sat port, no saturation logic.

Test Plan:
- 8-bit lanes (pw=010), a=0x01FF80FF, b=0x01010101, sub=0, ci=0, first -> c=0x02008100, co_lanes=0x0005, co=0, 1 cycle after fire.
- 32-bit lanes (pw=000): beat 1 a=0xFFFFFFFF, b=0x00000001, ci=0, first -> c=0, co=1. Beat 2 a=0, b=0, in_first=0 -> c=0x00000001, co=0.
- 16-bit lanes (pw=001), sub=1, ci=1, a=0x00050003, b=0x00010004 -> c=0x0004FFFF, co_lanes=0x0002, co=1.
- Backpressure: out_ready=0 after a result -> in_ready=0; a second beat is not accepted; c is held. Raise out_ready -> the second beat fires on the same edge the first is accepted.
- g_reset=1 between beat 1 and beat 2 of a multi-beat op -> out_valid=0, co_lanes=0. A following in_first=0 beat uses first-beat carry-ins (a=0, b=0, ci=0 -> c=0).
- SCARV_COP_PALU_SAT_EN: pw=010, sat=1, a=0xF0F0F0F0, b=0x20202020 -> c=0xFFFFFFFF, co_lanes=0x000F. Next beat with in_first=0 uses fresh carry-ins.
